// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel format and the alignment-pipeline stage type
// for the frame reader.
package vga_pkg;

   localparam int VGA_H_ACTIVE     = 640;
   localparam int VGA_H_FP         = 16;
   localparam int VGA_H_SYNC       = 96;
   localparam int VGA_H_BP         = 48;
   localparam int VGA_H_TOTAL      = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
   localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;

   localparam int VGA_V_ACTIVE     = 480;
   localparam int VGA_V_FP         = 10;
   localparam int VGA_V_SYNC       = 2;
   localparam int VGA_V_BP         = 33;
   localparam int VGA_V_TOTAL      = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
   localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
   localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

   localparam int VGA_SRC_WIDTH    = 320;
   localparam int VGA_SRC_HEIGHT   = 240;
   localparam int VGA_ADDR_WIDTH   = $clog2(VGA_SRC_WIDTH * VGA_SRC_HEIGHT);

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // One slot of the alignment pipeline; tick marks the slot carrying a new pixel.
   typedef struct packed {
      logic tick;
      logic hsync_n;
      logic vsync_n;
      logic active;
      logic frame_start;
   } pipe_t;

   localparam pipe_t PIPE_RST = '{tick: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1,
                                  active: 1'b0, frame_start: 1'b0};

endpackage

// File: rtl/vga_frame_reader_if.sv
// VRAM read port plus VGA output bundle of the frame reader.
interface vga_frame_reader_if #(
   parameter int ADDR_WIDTH = vga_pkg::VGA_ADDR_WIDTH,
   parameter int DATA_WIDTH = 12
);
   logic [ADDR_WIDTH-1:0] pixel_read_address_o;
   logic [DATA_WIDTH-1:0] pixel_data_i;
   logic [3:0]            vga_r_o;
   logic [3:0]            vga_g_o;
   logic [3:0]            vga_b_o;
   logic                  hsync_o;
   logic                  vsync_o;
   logic                  video_on_o;
   logic                  frame_start_o;

   modport master (
      output pixel_read_address_o, vga_r_o, vga_g_o, vga_b_o,
             hsync_o, vsync_o, video_on_o, frame_start_o,
      input  pixel_data_i
   );

   modport slave (
      input  pixel_read_address_o, vga_r_o, vga_g_o, vga_b_o,
             hsync_o, vsync_o, video_on_o, frame_start_o,
      output pixel_data_i
   );
endinterface

// File: rtl/vga_timing_generator.sv
// Pixel-tick divider and h/v scan counters; registers the sync/active/frame_start
// flags of the position being scanned on each tick (first alignment stage).
module vga_timing_generator
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP
) (
   input  logic  clk_i,
   input  logic  reset_i,
   output logic  tick_o,
   output logic  active_o,
   output logic  h_odd_o,
   output logic  v_odd_o,
   output logic  line_end_o,
   output logic  frame_end_o,
   output pipe_t stage_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] H_LAST_C   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HS_BEG_C   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_LAST_C   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] VS_BEG_C   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [DW-1:0] DIV_LAST_C = DW'(CLK_DIV - 1);

   logic [DW-1:0] div_q, div_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   pipe_t         stage_q, stage_d;

   // Counter reset value 0 makes the very first post-reset cycle a tick.
   assign tick_o      = (div_q == '0);
   assign active_o    = (h_q < H_ACT_C) && (v_q < V_ACT_C);
   assign h_odd_o     = h_q[0];
   assign v_odd_o     = v_q[0];
   assign line_end_o  = (h_q == H_ACT_LAST);
   assign frame_end_o = (h_q == H_LAST_C) && (v_q == V_LAST_C);
   assign stage_o     = stage_q;

   always_comb begin
      div_d        = (div_q == DIV_LAST_C) ? '0 : div_q + 1'b1;
      h_d          = h_q;
      v_d          = v_q;
      stage_d      = stage_q;
      stage_d.tick = tick_o;
      if (tick_o) begin
         stage_d.hsync_n     = !((h_q >= HS_BEG_C) && (h_q < HS_END_C));
         stage_d.vsync_n     = !((v_q >= VS_BEG_C) && (v_q < VS_END_C));
         stage_d.active      = active_o;
         stage_d.frame_start = (h_q == '0) && (v_q == '0);
         if (h_q == H_LAST_C) begin
            h_d = '0;
            v_d = (v_q == V_LAST_C) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         stage_q <= PIPE_RST;
      end else begin
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         stage_q <= stage_d;
      end
   end

endmodule

// File: rtl/vga_frame_reader.sv
// Scans a 320x240 RGB444 frame buffer out as 2x-doubled VGA; generates VRAM
// addresses and aligns sync/colour/markers to the returned read data.
module vga_frame_reader
   import vga_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int READ_LATENCY = 1,
   parameter int H_ACTIVE     = VGA_H_ACTIVE,
   parameter int H_FP         = VGA_H_FP,
   parameter int H_SYNC       = VGA_H_SYNC,
   parameter int H_BP         = VGA_H_BP,
   parameter int V_ACTIVE     = VGA_V_ACTIVE,
   parameter int V_FP         = VGA_V_FP,
   parameter int V_SYNC       = VGA_V_SYNC,
   parameter int V_BP         = VGA_V_BP,
   parameter int SRC_WIDTH    = VGA_SRC_WIDTH,
   parameter int SRC_HEIGHT   = VGA_SRC_HEIGHT,
   parameter int ADDR_WIDTH   = VGA_ADDR_WIDTH,
   parameter int DATA_WIDTH   = 12
) (
   input  logic              clk_i,
   input  logic              reset_i,
   vga_frame_reader_if.master bus
);

   localparam int            LW          = ADDR_WIDTH + 1;
   localparam logic [LW-1:0] SRC_W_C     = LW'(SRC_WIDTH);
   localparam logic [LW-1:0] FB_PIXELS_C = LW'(SRC_WIDTH * SRC_HEIGHT);

   logic  tick, active, h_odd, v_odd, line_end, frame_end;
   pipe_t stage0;

   vga_timing_generator #(
      .CLK_DIV  (CLK_DIV),
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .tick_o      (tick),
      .active_o    (active),
      .h_odd_o     (h_odd),
      .v_odd_o     (v_odd),
      .line_end_o  (line_end),
      .frame_end_o (frame_end),
      .stage_o     (stage0)
   );

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] lb_q, lb_d;
   logic [LW-1:0]         lb_next;

   // ptr_q is the address of the next pixel to present: it steps once per
   // source pixel (after odd h) and falls back to line_base on even lines so
   // every source line is read twice.
   always_comb begin
      addr_d  = addr_q;
      ptr_d   = ptr_q;
      lb_d    = lb_q;
      lb_next = {1'b0, lb_q} + SRC_W_C;
      if (tick) begin
         if (active) begin
            addr_d = ptr_q;
            if (line_end) begin
               if (!v_odd) begin
                  ptr_d = lb_q;
               end else if (lb_next >= FB_PIXELS_C) begin
                  lb_d  = '0;
                  ptr_d = '0;
               end else begin
                  lb_d  = lb_next[ADDR_WIDTH-1:0];
                  ptr_d = lb_next[ADDR_WIDTH-1:0];
               end
            end else if (h_odd) begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         if (frame_end) begin
            lb_d  = '0;
            ptr_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         addr_q <= '0;
         ptr_q  <= '0;
         lb_q   <= '0;
      end else begin
         addr_q <= addr_d;
         ptr_q  <= ptr_d;
         lb_q   <= lb_d;
      end
   end

   pipe_t                 chain_q [READ_LATENCY];
   pipe_t                 last;
   logic [DATA_WIDTH-1:0] pix;
   rgb444_t               rgb_q;
   logic                  hs_q, vs_q, von_q, fs_q;

   assign last = chain_q[READ_LATENCY-1];
   assign pix  = bus.pixel_data_i;

   // The final stage loads only in the cycle the tick reaches it, so outputs
   // hold between ticks and frame_start is a single-clk pulse.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < READ_LATENCY; i++) chain_q[i] <= PIPE_RST;
         rgb_q <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         von_q <= 1'b0;
         fs_q  <= 1'b0;
      end else begin
         chain_q[0] <= stage0;
         for (int i = 1; i < READ_LATENCY; i++) chain_q[i] <= chain_q[i-1];
         fs_q <= 1'b0;
         if (last.tick) begin
            rgb_q <= last.active ? pix : '0;
            hs_q  <= last.hsync_n;
            vs_q  <= last.vsync_n;
            von_q <= last.active;
            fs_q  <= last.frame_start;
         end
      end
   end

   assign bus.pixel_read_address_o = addr_q;
   assign bus.vga_r_o              = rgb_q.r;
   assign bus.vga_g_o              = rgb_q.g;
   assign bus.vga_b_o              = rgb_q.b;
   assign bus.hsync_o              = hs_q;
   assign bus.vsync_o              = vs_q;
   assign bus.video_on_o           = von_q;
   assign bus.frame_start_o        = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench: a full-size 640x480 reader for line timing/addresses/data and
// a shrunken-timing reader for frame wrap, blanking, vsync and mid-frame reset.
module tb_vga_frame_reader;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = -1;

   always #5 clk = ~clk;

   vga_frame_reader_if #(.ADDR_WIDTH(17), .DATA_WIDTH(12)) bus_f ();
   vga_frame_reader_if #(.ADDR_WIDTH(5),  .DATA_WIDTH(12)) bus_s ();

   vga_frame_reader dut_f (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus_f)
   );

   // 24x12 timing at CLK_DIV 4 -> 1152 clks per frame; 8x4 source buffer.
   vga_frame_reader #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
      .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (1),
      .SRC_WIDTH (8), .SRC_HEIGHT (4), .ADDR_WIDTH (5)
   ) dut_s (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus_s)
   );

   // VRAM with one-cycle latency: only address 5 holds a non-zero pixel.
   always @(posedge clk)
      bus_f.pixel_data_i <= (bus_f.pixel_read_address_o == 17'd5) ? 12'hA5C : 12'h000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after post-reset edge k (edge 0 = first tick).
   task automatic run_to(input int k);
      while (cyc < k) begin
         @(posedge clk);
         cyc++;
      end
      #1;
   endtask

   function automatic logic [31:0] rgb_f();
      return {20'd0, bus_f.vga_r_o, bus_f.vga_g_o, bus_f.vga_b_o};
   endfunction

   function automatic logic [31:0] rgb_s();
      return {20'd0, bus_s.vga_r_o, bus_s.vga_g_o, bus_s.vga_b_o};
   endfunction

   initial begin
      reset              = 1'b1;
      bus_s.pixel_data_i = 12'hFFF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_f_hsync", bus_f.hsync_o, 1);
      chk("rst_f_vsync", bus_f.vsync_o, 1);
      chk("rst_f_rgb", rgb_f(), 0);
      chk("rst_f_addr", bus_f.pixel_read_address_o, 0);
      chk("rst_f_von", bus_f.video_on_o, 0);
      chk("rst_f_fs", bus_f.frame_start_o, 0);
      chk("rst_s_hsync", bus_s.hsync_o, 1);
      reset = 1'b0;
      cyc   = -1;

      run_to(0);    chk("f_addr_h0", bus_f.pixel_read_address_o, 0);
      run_to(2);    chk("f_fs_first", bus_f.frame_start_o, 1);
                    chk("f_von_first", bus_f.video_on_o, 1);
                    chk("s_fs_first", bus_s.frame_start_o, 1);
                    chk("s_rgb_active", rgb_s(), 12'hFFF);
                    chk("s_von_active", bus_s.video_on_o, 1);
      run_to(3);    chk("f_fs_pulse_end", bus_f.frame_start_o, 0);
      run_to(4);    chk("f_addr_h1", bus_f.pixel_read_address_o, 0);
      run_to(8);    chk("f_addr_h2", bus_f.pixel_read_address_o, 1);
      run_to(38);   chk("f_rgb_px9", rgb_f(), 0);
      run_to(42);   chk("f_rgb_px10", rgb_f(), 12'hA5C);
      run_to(46);   chk("f_rgb_px11", rgb_f(), 12'hA5C);
      run_to(50);   chk("f_rgb_px12", rgb_f(), 0);
      run_to(66);   chk("s_rgb_hblank", rgb_s(), 0);
                    chk("s_von_hblank", bus_s.video_on_o, 0);
      run_to(73);   chk("s_hsync_pre", bus_s.hsync_o, 1);
      run_to(74);   chk("s_hsync_fall", bus_s.hsync_o, 0);
      run_to(89);   chk("s_hsync_last", bus_s.hsync_o, 0);
      run_to(90);   chk("s_hsync_rise", bus_s.hsync_o, 1);
      run_to(192);  chk("s_addr_line2", bus_s.pixel_read_address_o, 8);
      run_to(672);  chk("s_addr_line7_h0", bus_s.pixel_read_address_o, 24);
      run_to(732);  chk("s_addr_max", bus_s.pixel_read_address_o, 31);
      run_to(770);  chk("s_rgb_vblank", rgb_s(), 0);
                    chk("s_von_vblank", bus_s.video_on_o, 0);
      run_to(865);  chk("s_vsync_pre", bus_s.vsync_o, 1);
      run_to(866);  chk("s_vsync_fall", bus_s.vsync_o, 0);
      run_to(1057); chk("s_vsync_last", bus_s.vsync_o, 0);
      run_to(1058); chk("s_vsync_rise", bus_s.vsync_o, 1);
      run_to(1100); chk("s_addr_hold", bus_s.pixel_read_address_o, 31);
      run_to(1152); chk("s_addr_wrap", bus_s.pixel_read_address_o, 0);
      run_to(1153); chk("s_fs_pre", bus_s.frame_start_o, 0);
      run_to(1154); chk("s_fs_frame2", bus_s.frame_start_o, 1);
      run_to(1155); chk("s_fs_frame2_end", bus_s.frame_start_o, 0);
      run_to(2556); chk("f_addr_h639", bus_f.pixel_read_address_o, 319);
      run_to(2625); chk("f_hsync_pre", bus_f.hsync_o, 1);
      run_to(2626); chk("f_hsync_fall", bus_f.hsync_o, 0);
      run_to(2800); chk("f_addr_hold", bus_f.pixel_read_address_o, 319);
      run_to(3009); chk("f_hsync_last", bus_f.hsync_o, 0);
      run_to(3010); chk("f_hsync_rise", bus_f.hsync_o, 1);
      run_to(3200); chk("f_addr_line1_h0", bus_f.pixel_read_address_o, 0);
      run_to(3242); chk("f_rgb_l1_px10", rgb_f(), 12'hA5C);
      run_to(3246); chk("f_rgb_l1_px11", rgb_f(), 12'hA5C);
      run_to(5756); chk("f_addr_line1_h639", bus_f.pixel_read_address_o, 319);
      run_to(6400); chk("f_addr_line2_h0", bus_f.pixel_read_address_o, 320);
      run_to(6412); chk("f_addr_line2_h3", bus_f.pixel_read_address_o, 321);

      // Small reader at frame 9, v=5, h=10: line_base 16 + 5.
      run_to(10888);
      chk("s_mid_addr", bus_s.pixel_read_address_o, 21);
      chk("s_mid_von", bus_s.video_on_o, 1);
      chk("s_mid_rgb", rgb_s(), 12'hFFF);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mrst_s_addr", bus_s.pixel_read_address_o, 0);
      chk("mrst_s_hsync", bus_s.hsync_o, 1);
      chk("mrst_s_vsync", bus_s.vsync_o, 1);
      chk("mrst_s_von", bus_s.video_on_o, 0);
      chk("mrst_s_rgb", rgb_s(), 0);
      chk("mrst_s_fs", bus_s.frame_start_o, 0);
      chk("mrst_f_addr", bus_f.pixel_read_address_o, 0);
      chk("mrst_f_von", bus_f.video_on_o, 0);
      reset = 1'b0;
      cyc   = -1;
      run_to(0);    chk("rs_s_addr_h0", bus_s.pixel_read_address_o, 0);
      run_to(2);    chk("rs_s_fs", bus_s.frame_start_o, 1);
                    chk("rs_f_fs", bus_f.frame_start_o, 1);
                    chk("rs_s_von", bus_s.video_on_o, 1);
      run_to(8);    chk("rs_s_addr_h2", bus_s.pixel_read_address_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
- Downstream consumer of the VRAM frame buffer. Scans the 320x240 RGB444 frame and drives a 640x480@60 Hz VGA output, doubling each source pixel horizontally and vertically.
- Generates the VRAM read address and captures the returned pixel data.
- Emits sync, RGB and frame markers; all outputs are pipeline-aligned to each other.
- Runs entirely in the system clock domain.

Parameters:
- CLK_DIV, 4, system clocks per VGA pixel (100 MHz -> 25 MHz); must be > READ_LATENCY.
- READ_LATENCY, 1, VRAM read latency in clk_i cycles (address registered -> data valid).
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels (total 800).
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines (total 525).
- SRC_WIDTH, 320, frame buffer width in pixels.
- SRC_HEIGHT, 240, frame buffer height in lines.
- ADDR_WIDTH, $clog2(76800), VRAM address width.
- DATA_WIDTH, 12, pixel width: [11:8]=R, [7:4]=G, [3:0]=B.

Ports:
- clk_i  in  1  system clock; the only clock.
- reset_i  in  1  synchronous, active-high reset.
- pixel_read_address_o  out  ADDR_WIDTH  VRAM read address.
- pixel_data_i  in  DATA_WIDTH  VRAM read data, valid READ_LATENCY cycles after the address.
- vga_r_o / vga_g_o / vga_b_o  out  4 each  colour outputs.
- hsync_o  out  1  horizontal sync, active low.
- vsync_o  out  1  vertical sync, active low.
- video_on_o  out  1  high during active pixels.
- frame_start_o  out  1  one-clk pulse aligned with the output of pixel (0,0).

Behaviour:
- Reset (synchronous; also mid-frame):
  - tick divider, h_count, v_count, line_base and address all go to 0.
  - All pipeline stages clear.
  - Outputs: RGB=0, hsync_o=1, vsync_o=1, video_on_o=0, frame_start_o=0, pixel_read_address_o=0.
  - Scanning restarts at (0,0) in the first cycle after reset deasserts.
- Pixel tick:
  - A mod-CLK_DIV counter asserts tick on the cycle it wraps to 0.
  - The first tick after reset occurs on the first post-reset cycle.
  - h_count/v_count change only on a tick.
- Counters:
  - h_count runs 0..799 and wraps to 0; v_count increments when h_count wraps and itself wraps 524->0.
  - Active region: h<640 and v<480.
  - hsync low for h in 656..751; vsync low for v in 490..491.
- Address generation, updated on the tick that loads (h,v):
  - Active pixel: address = line_base + (h>>1).
  - Computed incrementally; no multiplier. The address increments after each odd active h.
  - At the end of each odd active line: line_base += SRC_WIDTH.
  - At frame wrap: line_base = 0.
  - Outside the active region the address holds its last value.
  - The address never exceeds 76799.
- Pipeline:
  - hsync, vsync, active and frame_start (h==0 && v==0) are delayed READ_LATENCY+1 clks from the counter update.
  - pixel_data_i is registered in the same final stage, so every output changes exactly READ_LATENCY+1 clks after its tick.
  - Outputs are held between ticks.
- Blanking: RGB is forced to 0 whenever the delayed active flag is 0.
- Frame period: 800*525*CLK_DIV = 1,680,000 clks. frame_start_o fires once per frame.

Decomposition:
- Package vga_pkg: timing constants (H_*/V_* totals, sync start/end), SRC_WIDTH/SRC_HEIGHT, an rgb444_t packed struct {r,g,b}.
- Sub-module vga_timing_generator:
  - Contains the tick divider, h/v counters, sync, active and frame_start flags.
  - vga_frame_reader instantiates it and adds address generation and the alignment pipeline.

Test Plan:
- Reset release, CLK_DIV=4 -> hsync_o=1, vsync_o=1, RGB=0 during reset; first hsync_o fall at tick 656 (clk 2624+READ_LATENCY+1); low for exactly 384 clks.
- Line 0 addresses sampled per tick -> 0,0,1,1,...,319,319; line 1 -> same 0..319 sequence; line 2 starts at 320.
- Line 479 -> addresses 76480..76799; next frame line 0 restarts at 0; frame_start_o pulses are exactly 1,680,000 clks apart.
- pixel_data_i = 12'hA5C at address 5 (model with latency 1) -> output pixels 10 and 11 of lines 0/1 show R=A, G=5, B=C.
- Blanking: pixel_data_i forced 12'hFFF -> RGB=0 for h>=640 or v>=480; video_on_o low there; vsync_o low for exactly 2*800*4 clks.
- reset_i pulsed mid-frame (v=200, h=300) for 1 clk -> next cycle all outputs at reset values; scan restarts at (0,0), address 0.
